// File: rtl/alu_pkg.sv
// Shared definitions for the alu block.
//   alu_op_e : 4-bit opcode encoding carried on the alu operation port.
//   ALU_OP_W : width of the opcode field.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_NOT = 4'd6,
    OP_SHL = 4'd7,
    OP_SHR = 4'd8
  } alu_op_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for the alu.
//   a      : value to shift
//   b      : shift amount, full unsigned value of the operand
//   left   : 1 = shift left, 0 = shift right
//   arith  : right shifts only; 1 = sign-fill, 0 = zero-fill
//   result : shifted value
// Shift amounts of N or more saturate: 0 for left/logical right,
// all copies of a[N-1] for arithmetic right.
module alu_shifter #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         left,
  input  logic         arith,
  output logic [N-1:0] result
);

  logic oversize;

  // Compare in a fixed 64-bit domain so the check works for every legal N.
  assign oversize = (64'(b) >= 64'(N));

  always_comb begin
    result = '0;
    if (left) begin
      result = oversize ? '0 : (a << b);
    end else if (arith) begin
      result = oversize ? {N{a[N-1]}} : N'($signed(a) >>> b);
    end else begin
      result = oversize ? '0 : (a >> b);
    end
  end

endmodule

// File: rtl/alu.sv
// N-bit integer ALU with registered outputs (1-cycle latency, one op per cycle).
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   a, b        : operands (b is also the shift amount)
//   operation   : opcode, see alu_pkg::alu_op_e; undefined codes give 0
//   is_signed   : two's-complement semantics for div and shr
//   result      : registered result
//   zero        : result is all zeros
//   carry       : add carry-out / sub borrow, 0 otherwise
//   overflow    : signed overflow of add/sub, 0 otherwise
//   div_by_zero : div with b == 0 (result forced to all ones)
module alu
  import alu_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        a,
  input  logic [N-1:0]        b,
  input  logic [ALU_OP_W-1:0] operation,
  input  logic                is_signed,
  output logic [N-1:0]        result,
  output logic                zero,
  output logic                carry,
  output logic                overflow,
  output logic                div_by_zero
);

  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

  alu_op_e      op;
  logic [N:0]   sum;
  logic [N:0]   diff;
  logic [N-1:0] prod;
  logic [N-1:0] quot;
  logic [N-1:0] shifted;
  logic         b_zero;

  logic [N-1:0] res_d;
  logic         carry_d;
  logic         ovf_d;
  logic         dbz_d;

  assign op     = alu_op_e'(operation);
  assign sum    = {1'b0, a} + {1'b0, b};
  assign diff   = {1'b0, a} - {1'b0, b};
  assign prod   = a * b;
  assign b_zero = (b == '0);

  // Zero divisor and most-negative / -1 are resolved explicitly so the
  // native divide operator never sees an undefined case.
  always_comb begin
    quot = '0;
    if (b_zero) begin
      quot = '1;
    end else if (is_signed) begin
      if (a == MOST_NEG && b == '1) begin
        quot = MOST_NEG;
      end else begin
        quot = N'($signed(a) / $signed(b));
      end
    end else begin
      quot = a / b;
    end
  end

  alu_shifter #(.N(N)) u_shifter (
    .a      (a),
    .b      (b),
    .left   (op == OP_SHL),
    .arith  (is_signed),
    .result (shifted)
  );

  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    dbz_d   = 1'b0;
    case (op)
      OP_ADD: begin
        res_d   = sum[N-1:0];
        carry_d = sum[N];
        ovf_d   = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      OP_SUB: begin
        res_d   = diff[N-1:0];
        carry_d = diff[N];
        ovf_d   = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
      end
      OP_MUL: res_d = prod;
      OP_DIV: begin
        res_d = quot;
        dbz_d = b_zero;
      end
      OP_AND: res_d = a & b;
      OP_OR:  res_d = a | b;
      OP_NOT: res_d = ~a;
      OP_SHL: res_d = shifted;
      OP_SHR: res_d = shifted;
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result      <= '0;
      zero        <= 1'b1;
      carry       <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      result      <= res_d;
      zero        <= (res_d == '0);
      carry       <= carry_d;
      overflow    <= ovf_d;
      div_by_zero <= dbz_d;
    end
  end

endmodule

// File: tb/tb_alu.sv
module tb_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] operation;
  logic       is_signed;
  logic [7:0] result;
  logic       zero;
  logic       carry;
  logic       overflow;
  logic       div_by_zero;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic        issue  = 1'b0;
  logic        done   = 1'b0;

  typedef struct {
    string      name;
    logic [7:0] res;
    logic       z;
    logic       c;
    logic       o;
    logic       d;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  alu #(.N(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .b           (b),
    .operation   (operation),
    .is_signed   (is_signed),
    .result      (result),
    .zero        (zero),
    .carry       (carry),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  // Drive one cycle of stimulus and queue its expected response.
  task automatic apply(input string nm, input logic r, input logic [3:0] op,
                       input logic [7:0] av, input logic [7:0] bv, input logic s,
                       input logic [7:0] er, input logic ez, input logic ec,
                       input logic eo, input logic ed);
    exp_t e;
    @(negedge clk);
    rst       = r;
    operation = op;
    a         = av;
    b         = bv;
    is_signed = s;
    issue     = 1'b1;
    e.name = nm; e.res = er; e.z = ez; e.c = ec; e.o = eo; e.d = ed;
    q.push_back(e);
  endtask

  // Monitor: an op issued before edge k is checked just after edge k.
  initial begin : monitor
    logic chk;
    exp_t e;
    forever begin
      @(posedge clk);
      chk = issue;
      #1;
      if (chk) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL queue_underflow: output present with no expectation");
        end else begin
          e = q.pop_front();
          if (result !== e.res || zero !== e.z || carry !== e.c ||
              overflow !== e.o || div_by_zero !== e.d) begin
            errors++;
            $display("FAIL %s: got res=%h z=%b c=%b o=%b dbz=%b, want res=%h z=%b c=%b o=%b dbz=%b",
                     e.name, result, zero, carry, overflow, div_by_zero,
                     e.res, e.z, e.c, e.o, e.d);
          end
        end
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1; a = 8'hA5; b = 8'h5A; operation = 4'd2; is_signed = 1'b1;

    // Reset, then a zero-producing op
    apply("reset_0", 1, 4'd1, 8'h33, 8'h77, 1, 8'h00, 1, 0, 0, 0);
    apply("reset_1", 1, 4'd3, 8'h80, 8'hFF, 0, 8'h00, 1, 0, 0, 0);
    apply("post_reset_idle", 0, 4'd0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 0, 0);

    // Unsigned a=0x0F b=0x03
    apply("u0f_add", 0, 4'd0, 8'h0F, 8'h03, 0, 8'h12, 0, 0, 0, 0);
    apply("u0f_sub", 0, 4'd1, 8'h0F, 8'h03, 0, 8'h0C, 0, 0, 0, 0);
    apply("u0f_mul", 0, 4'd2, 8'h0F, 8'h03, 0, 8'h2D, 0, 0, 0, 0);
    apply("u0f_div", 0, 4'd3, 8'h0F, 8'h03, 0, 8'h05, 0, 0, 0, 0);
    apply("u0f_and", 0, 4'd4, 8'h0F, 8'h03, 0, 8'h03, 0, 0, 0, 0);
    apply("u0f_or",  0, 4'd5, 8'h0F, 8'h03, 0, 8'h0F, 0, 0, 0, 0);
    apply("u0f_not", 0, 4'd6, 8'h0F, 8'h03, 0, 8'hF0, 0, 0, 0, 0);
    apply("u0f_shl", 0, 4'd7, 8'h0F, 8'h03, 0, 8'h78, 0, 0, 0, 0);
    apply("u0f_shr", 0, 4'd8, 8'h0F, 8'h03, 0, 8'h01, 0, 0, 0, 0);

    // Unsigned a=0xF0 b=0x0F (shift amounts >= N saturate)
    apply("uf0_add", 0, 4'd0, 8'hF0, 8'h0F, 0, 8'hFF, 0, 0, 0, 0);
    apply("uf0_sub", 0, 4'd1, 8'hF0, 8'h0F, 0, 8'hE1, 0, 0, 0, 0);
    apply("uf0_mul", 0, 4'd2, 8'hF0, 8'h0F, 0, 8'h10, 0, 0, 0, 0);
    apply("uf0_div", 0, 4'd3, 8'hF0, 8'h0F, 0, 8'h10, 0, 0, 0, 0);
    apply("uf0_and", 0, 4'd4, 8'hF0, 8'h0F, 0, 8'h00, 1, 0, 0, 0);
    apply("uf0_or",  0, 4'd5, 8'hF0, 8'h0F, 0, 8'hFF, 0, 0, 0, 0);
    apply("uf0_not", 0, 4'd6, 8'hF0, 8'h0F, 0, 8'h0F, 0, 0, 0, 0);
    apply("uf0_shl", 0, 4'd7, 8'hF0, 8'h0F, 0, 8'h00, 1, 0, 0, 0);
    apply("uf0_shr", 0, 4'd8, 8'hF0, 8'h0F, 0, 8'h00, 1, 0, 0, 0);

    // Signed
    apply("s_div_neg",   0, 4'd3, 8'hF0, 8'h0F, 1, 8'hFF, 0, 0, 0, 0);
    apply("s_shr_big",   0, 4'd8, 8'hF0, 8'h0F, 1, 8'hFF, 0, 0, 0, 0);
    apply("s_shr_2",     0, 4'd8, 8'hF0, 8'h02, 1, 8'hFC, 0, 0, 0, 0);
    apply("s_add_ovf",   0, 4'd0, 8'h7F, 8'h01, 1, 8'h80, 0, 0, 1, 0);

    // Edge cases
    apply("div_by_zero", 0, 4'd3, 8'h05, 8'h00, 0, 8'hFF, 0, 0, 0, 1);
    apply("s_div_min",   0, 4'd3, 8'h80, 8'hFF, 1, 8'h80, 0, 0, 0, 0);
    apply("sub_borrow",  0, 4'd1, 8'h03, 8'h05, 0, 8'hFE, 0, 1, 0, 0);
    apply("bad_opcode",  0, 4'd9, 8'h5A, 8'h3C, 0, 8'h00, 1, 0, 0, 0);
    apply("add_carry",   0, 4'd0, 8'hFF, 8'h01, 0, 8'h00, 1, 1, 0, 0);
    apply("shl_7",       0, 4'd7, 8'h01, 8'h07, 0, 8'h80, 0, 0, 0, 0);
    apply("sub_ovf",     0, 4'd1, 8'h80, 8'h01, 0, 8'h7F, 0, 0, 1, 0);

    // Reset beats an add in the same cycle
    apply("rst_priority", 1, 4'd0, 8'h01, 8'h01, 0, 8'h00, 1, 0, 0, 0);

    @(negedge clk);
    issue = 1'b0;
    rst   = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d expectations left, want 0", q.size());
    end
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    if (!done) begin
      $display("FAIL watchdog: bench did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
    end
  end

endmodule
